// File: rtl/pwm_fader.sv
// Multi-channel PWM driver with tick-sampled duty targets, optional linear
// fading, and per-period shadowing of the active duty for glitch-free output.

// One PWM channel: fade/direct/hold update of cur, shadow load, output register.
module pwm_fader_ch #(
    parameter int WIDTH  = 8,
    parameter int STEP   = 1,
    parameter int INVERT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             upd,
    input  logic             load,
    input  logic [WIDTH-1:0] pcnt,
    input  logic [WIDTH-1:0] target,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] act,
    output logic             pwm
);
    localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam logic             INV    = 1'(INVERT);

    logic [WIDTH:0]   cur_x, tgt_x, up_x;
    logic [WIDTH-1:0] nxt;

    assign cur_x = {1'b0, cur};
    assign tgt_x = {1'b0, target};
    assign up_x  = cur_x + STEP_X;

    // Next duty for this tick; fade math is one bit wider so it clamps to target.
    always_comb begin
        nxt = cur;
        case (mode)
            2'b00: nxt = target;
            2'b01: begin
                if (cur < target)
                    nxt = (up_x >= tgt_x) ? target : up_x[WIDTH-1:0];
                else if (cur > target)
                    nxt = (cur_x >= tgt_x + STEP_X) ? (cur - STEP_W) : target;
            end
            default: nxt = cur;
        endcase
    end

    // Current duty advances only on the update tick.
    always_ff @(posedge clk) begin
        if (!rst_n)   cur <= '0;
        else if (upd) cur <= nxt;
    end

    // Shadow copy taken at the period boundary; output compares against it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act <= '0;
            pwm <= INV;
        end else begin
            if (load) act <= cur;
            pwm <= (pcnt < act) ^ INV;
        end
    end
endmodule

module pwm_fader #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 2500000,
    parameter int STEP     = 1,
    parameter int INVERT   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] target,
    input  logic [1:0]                mode,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic [CHANNELS*WIDTH-1:0] duty,
    output logic                      tick,
    output logic                      busy,
    output logic                      any_on
);
    localparam int TW = $clog2(TICK_DIV);

    logic [TW-1:0]                        tdiv;
    logic [WIDTH-1:0]                     pcnt;
    logic                                 tick_edge, boundary;
    logic [CHANNELS-1:0][WIDTH-1:0]       cur, act;

    assign tick_edge = (tdiv == TW'(TICK_DIV - 1));
    assign boundary  = &pcnt;
    assign duty      = cur;

    // Update tick divider and its registered one-cycle pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tdiv <= '0;
            tick <= 1'b0;
        end else begin
            tdiv <= tick_edge ? '0 : tdiv + 1'b1;
            tick <= tick_edge;
        end
    end

    // Shared free-running PWM counter; any_on follows the shadow duties.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt   <= '0;
            any_on <= 1'b0;
        end else begin
            pcnt   <= pcnt + 1'b1;
            any_on <= |act;
        end
    end

    // busy is combinational so it reacts to target changes immediately.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < CHANNELS; i++)
            if (cur[i] != target[i*WIDTH +: WIDTH]) busy = 1'b1;
    end

    pwm_fader_ch #(.WIDTH(WIDTH), .STEP(STEP), .INVERT(INVERT)) u_ch [CHANNELS-1:0] (
        .clk    (clk),
        .rst_n  (rst_n),
        .upd    (tick_edge),
        .load   (boundary),
        .pcnt   (pcnt),
        .target (target),
        .mode   (mode),
        .cur    (cur),
        .act    (act),
        .pwm    (pwm_out)
    );
endmodule

// File: doc/pwm_fader.md
# pwm_fader

Parametrised multi-channel PWM driver with per-tick duty update and optional linear fading. It replaces the fixed three-channel, 8-bit, snap-update LED path behind the keyboard decoder. Duty targets arrive as a packed bus (e.g. `k_board` data), are sampled on an internal update tick, and are either applied directly or ramped toward in fixed steps. Each channel's active duty changes only at a PWM period boundary, so no output glitches.

## Interface

- `CHANNELS`, 3: number of PWM channels.
- `WIDTH`, 8: duty and PWM counter width; period is 2^WIDTH clk cycles.
- `TICK_DIV`, 2500000: update tick period in clk cycles (≥2).
- `STEP`, 1: fade increment per tick (1 ≤ STEP ≤ 2^WIDTH-1).
- `INVERT`, 1: 1 = active-low outputs (common-anode LED), 0 = active-high.

- `clk`  in  1  system clock (25 MHz on board).
- `rst_n`  in  1  synchronous active-low reset.
- `target`  in  CHANNELS*WIDTH  packed target duties; channel i = bits [i*WIDTH +: WIDTH].
- `mode`  in  2  00 direct, 01 fade, 10 hold, 11 treated as hold.
- `pwm_out`  out  CHANNELS  PWM outputs, polarity per INVERT.
- `duty`  out  CHANNELS*WIDTH  current (pre-shadow) duty per channel.
- `tick`  out  1  one-cycle pulse on each update tick.
- `busy`  out  1  any channel's current duty ≠ its target.
- `any_on`  out  1  OR of all active (shadow) duties ≠ 0.

## Operation

- Tick divider: `tdiv` counts 0..TICK_DIV-1 and wraps. `tick` is registered and asserted for one cycle during the cycle after `tdiv` == TICK_DIV-1.
- Update happens on the edge where `tdiv` == TICK_DIV-1. The per-channel `cur` and `target` are sampled on that same edge.
  - direct: `cur` <= `target`.
  - fade: if `cur` < `target`, then `cur` <= min(`cur`+STEP, `target`). If `cur` > `target`, then `cur` <= max(`cur`-STEP, `target`). If equal, no change.
  - hold / 11: no change.
  - Fade arithmetic is done in WIDTH+1 bits. It clamps to the target and never wraps past 0 or 2^WIDTH-1.
- Between ticks, changes to `target` and `mode` have no effect. A target change mid-fade ramps from the present `cur` toward the new target. A mode change takes effect at the next tick.
- PWM counter: `pcnt` is WIDTH bits, free-running, and wraps from 2^WIDTH-1 to 0. All channels share it.
- Shadow: `act[i]` <= `cur[i]` on the edge where `pcnt` == 2^WIDTH-1. The new duty therefore starts with `pcnt` = 0.
- Output: `pwm_out[i]` is registered as (`pcnt` < `act[i]`) XOR INVERT.
  - `act` = 0 gives a constant off level.
  - `act` = 2^WIDTH-1 gives on for 2^WIDTH-1 of 2^WIDTH cycles. 100% on is not reachable.
- `duty` = `cur`.
- `busy` = OR over channels of (`cur[i]` ≠ `target[i]`), combinational from registers and inputs.
- `any_on` is registered from `act`.

## Timing

- Reset (`rst_n` = 0 at a clk edge) clears `tdiv`, `pcnt`, `cur`, `act`, `tick`, `any_on` and `duty` to 0.
  - `pwm_out` = {CHANNELS{INVERT}}, i.e. all off.
  - `busy` = (`target` ≠ 0).
  - Reset wins over a coincident tick or boundary. A reset in the middle of a fade aborts it, with no resume.
- Latency, target to `cur`: direct mode updates at the first tick edge after `target` is stable, which is at most TICK_DIV cycles.
- Latency, `cur` to `pwm_out`: at most 2^WIDTH cycles for the shadow load, plus 1 cycle for the output register.
- A fade from a to b needs ceil(|b-a|/STEP) ticks.
- If a tick edge and a PWM boundary edge coincide, `act` loads the pre-update `cur`. The new `cur` is shadowed at the next boundary.
- After reset is released, the first tick occurs TICK_DIV cycles later.

## Test plan

All scenarios use CHANNELS=3, WIDTH=4, TICK_DIV=4, STEP=3, INVERT=1.

- **Reset:** hold `rst_n`=0 for 3 cycles with `target`=0xFFF -> `pwm_out`=3'b111, `duty`=0, `tick`=0, `any_on`=0, `busy`=1.
- **Direct mode:** set ch0 target to 8 -> `duty`[3:0]=8 after the first tick. From the next period start, `pwm_out[0]` is low for 8 cycles and high for 8 cycles, repeating every 16 cycles.
- **Fade up:** ch1 goes from 0 toward 10 -> `duty`[7:4] takes the values 3, 6, 9, 10 on successive ticks. `busy` drops in the cycle `cur` reaches 10.
- **Fade down with retarget:** ch2 fades from 15 toward 0. Change the target to 7 after the value reaches 9 -> the sequence is 15, 12, 9, 7, then it holds at 7.
- **Hold and boundaries:** in mode 10, changing `target` leaves `duty` unchanged across 5 ticks.
  - `act`=0 gives `pwm_out` constantly 1.
  - `act`=15 gives exactly one high cycle per 16-cycle period.
- **Glitch-free update and reset mid-fade:**
  - Change `cur` when `pcnt`=5 -> the pulse width of the current period is unchanged, and the new width starts at `pcnt`=0.
  - Assert `rst_n`=0 during a fade -> all outputs are at their reset values on the next edge.
